sram_axi_req_arbiter: RTL
=========================

Name: sram_axi_req_arbiter

Overview:
- Sits between the CPU's two SRAM-like ports (inst, data) and the bridge's read-issue and write-issue engines.
- Decides which requester owns the read-issue path each cycle and gates addr_ok on credit, order and hazards.
- Counts outstanding transactions per requester and routes responses back as data_ok/rdata by ID.
- Guarantees in-order data_ok per requester and read-after-write safety for inst fetches.

Parameters:
MAX_RD_OUT, 2, max outstanding reads per requester (1..4)
MAX_WR_OUT, 2, max outstanding writes; also the depth of the pending-write address FIFO (1..4)
ID_INST, 4'd0, read ID tagged on inst reads
ID_DATA, 4'd1, read ID tagged on data reads

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  inst request; wr, wstrb and wdata are ignored, inst is read-only
inst_sram_addr_ok  out  1  inst request accepted this cycle
inst_sram_data_ok  out  1  inst read data valid
inst_sram_rdata  out  32  inst read data
data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data request
data_sram_addr_ok  out  1  data request accepted
data_sram_data_ok  out  1  data read data valid or write complete
data_sram_rdata  out  32  data read data
rd_issue_valid  out  1  read request to the read-issue engine
rd_issue_ready  in  1  read-issue engine accepts
rd_issue_id  out  4  ID_INST or ID_DATA
rd_issue_addr  out  32  read address
rd_issue_size  out  3  {1'b0,size}
rd_resp_valid  in  1  read beat returned; always accepted
rd_resp_id  in  4  ID of the returned beat
rd_resp_data  in  32  returned data
wr_issue_valid  out  1  write request to the write-issue engine
wr_issue_ready  in  1  write-issue engine accepts
wr_issue_addr/size/wstrb/wdata  out  32/3/4/32  write payload
wr_resp_valid  in  1  write response (B) received; always accepted

Behaviour:
- Single clock domain. Reset is synchronous and active-low on resetn. All registers clear on resetn==0: counters 0, write FIFO empty.
- addr_ok and issue outputs are combinational from the current requests and state, giving zero-cycle accept. data_ok/rdata are combinational passthrough of responses.
- A handshake is valid&ready. addr_ok is asserted exactly when the matching issue handshake occurs.
- Eligibility for a data read (data_req & !data_wr), all must hold:
  - rd_cnt_d < MAX_RD_OUT
  - wr_cnt == 0 (no mixing of data read and write in flight, which preserves data_ok order)
- Eligibility for a data write (data_req & data_wr), all must hold:
  - rd_cnt_d == 0
  - wr_cnt < MAX_WR_OUT
  - write FIFO not full
- Eligibility for an inst read, all must hold:
  - rd_cnt_i < MAX_RD_OUT
  - inst_addr[31:2] matches no valid entry in the pending-write FIFO (RAW hazard for self-modifying code)
- Read arbitration is fixed priority: an eligible data read beats an eligible inst read.
  - rd_issue_valid = (chosen requester exists).
  - rd_issue_id/addr/size are taken from the winner.
  - The loser's addr_ok is 0.
- Write path is independent of the read path. wr_issue_valid = eligible data write. A data write and an inst read may be accepted in the same cycle.
- rd_issue_valid must not depend on rd_issue_ready (AXI-safe).
- Counters:
  - rd_cnt_x increments on an issue handshake and decrements on rd_resp_valid with the matching ID.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - wr_cnt behaves the same way using wr_issue handshake and wr_resp_valid.
- Write FIFO:
  - Pushes addr[31:2] on the wr_issue handshake and pops on wr_resp_valid (in-order B).
  - Push and pop in the same cycle are allowed when full.
- Response routing:
  - rd_resp ID_INST gives inst_data_ok=1 and inst_rdata=data.
  - rd_resp ID_DATA gives data_data_ok=1 and data_rdata=data.
  - wr_resp gives data_data_ok=1 and data_rdata=0.
  - A rd_resp and a wr_resp arriving for data in the same cycle is impossible by construction; flag it via an assertion.
  - rdata is 0 when data_ok=0.
- Stray responses arrive when the matching counter is 0, e.g. after reset mid-transaction. They are dropped: no data_ok, counter stays 0, no underflow.
- An unknown rd_resp_id is dropped.

Decomposition:
- Shared package: ID_INST/ID_DATA, the size-to-arsize mapping, and the counter width function clog2(MAX+1).
- One sub-module: sram_wr_addr_fifo. Parameters are depth and width 30. Ports are push, pop, full, empty, plus a parallel match output (per-entry valid & addr compare) against one lookup address.

Test Plan:
- Both req, data read 0x100 and inst 0x200, both readys=1 → data_addr_ok=1, rd_issue_id=1, addr 0x100; inst_addr_ok=0; next cycle inst is issued with id 0.
- 3 back-to-back inst reads, no responses, MAX_RD_OUT=2 → third addr_ok=0 until one rd_resp id0 arrives; inst_data_ok pulses once per resp with matching rdata.
- Data write 0x40 outstanding, then inst read 0x40 → inst stalled until wr_resp_valid; inst read 0x44 is issued immediately.
- Data write outstanding, then data read → data_addr_ok=0 until wr_resp; data_data_ok order is write then read.
- Write and inst read on the same cycle with both readys → both addr_ok=1 together; wr_cnt=1 and rd_cnt_i=1.
- resetn low for 1 cycle with 2 reads in flight, then 2 rd_resp → no data_ok, counters remain 0.

Source files
------------

// File: rtl/sram_axi_req_arbiter_pkg.sv
// Shared definitions for the SRAM-to-AXI request arbiter.
//   ID_INST_DEF / ID_DATA_DEF : default read IDs for the inst and data requesters
//   WADDR_W                   : width of a word address (addr[31:2])
//   size_to_axsize()          : SRAM 2-bit size to AXI 3-bit AxSIZE
//   cnt_w()                   : counter width able to hold 0..max_out
package sram_axi_req_arbiter_pkg;

    localparam logic [3:0] ID_INST_DEF = 4'd0;
    localparam logic [3:0] ID_DATA_DEF = 4'd1;
    localparam int         WADDR_W     = 30;

    function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

    function automatic int cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/sram_axi_req_arbiter_wr_addr_fifo.sv
// Pending-write word-address FIFO. Holds the word addresses of writes that have
// been issued but whose B response has not yet come back, in issue order.
//   clk, resetn  : clock, synchronous active-low reset (clears all valid bits)
//   push         : push push_addr (accepted when not full, or when popping)
//   pop          : retire the oldest entry (ignored when empty)
//   lookup_addr  : word address compared in parallel against every valid entry
//   full, empty  : occupancy flags
//   match        : some valid entry equals lookup_addr
module sram_wr_addr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    input  logic [WIDTH-1:0] lookup_addr,
    output logic             full,
    output logic             empty,
    output logic             match
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] hit;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = &vld_q;
    assign empty   = ~|vld_q;
    assign do_pop  = pop & ~empty;
    // When full, the slot being freed by the pop is the one the push lands in.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        vld_d    = vld_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            vld_d[wr_ptr_q] = 1'b1;
            mem_d[wr_ptr_q] = push_addr;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = vld_q[i] && (mem_q[i] == lookup_addr);
        end
    end

    assign match = |hit;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sram_axi_req_arbiter.sv
// Arbiter between the CPU inst/data SRAM-like ports and the AXI bridge
// read-issue / write-issue engines.
//   inst_sram_*   : read-only fetch port (wr/wstrb/wdata ignored)
//   data_sram_*   : load/store port
//   rd_issue_*    : read request to the read-issue engine (valid/ready)
//   rd_resp_*     : returned read beats, tagged by ID, always accepted
//   wr_issue_*    : write request to the write-issue engine (valid/ready)
//   wr_resp_valid : write B response, always accepted
// addr_ok and issue outputs are combinational (zero-cycle accept); data_ok and
// rdata are combinational passthrough of the responses.
module sram_axi_req_arbiter
    import sram_axi_req_arbiter_pkg::*;
#(
    parameter int         MAX_RD_OUT = 2,
    parameter int         MAX_WR_OUT = 2,
    parameter logic [3:0] ID_INST    = ID_INST_DEF,
    parameter logic [3:0] ID_DATA    = ID_DATA_DEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        rd_issue_valid,
    input  logic        rd_issue_ready,
    output logic [3:0]  rd_issue_id,
    output logic [31:0] rd_issue_addr,
    output logic [2:0]  rd_issue_size,
    input  logic        rd_resp_valid,
    input  logic [3:0]  rd_resp_id,
    input  logic [31:0] rd_resp_data,

    output logic        wr_issue_valid,
    input  logic        wr_issue_ready,
    output logic [31:0] wr_issue_addr,
    output logic [2:0]  wr_issue_size,
    output logic [3:0]  wr_issue_wstrb,
    output logic [31:0] wr_issue_wdata,
    input  logic        wr_resp_valid
);

    localparam int              RD_CW  = cnt_w(MAX_RD_OUT);
    localparam int              WR_CW  = cnt_w(MAX_WR_OUT);
    localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_OUT);
    localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_OUT);

    logic [RD_CW-1:0] rd_cnt_inst_q, rd_cnt_inst_d;
    logic [RD_CW-1:0] rd_cnt_data_q, rd_cnt_data_d;
    logic [WR_CW-1:0] wr_cnt_q, wr_cnt_d;

    logic data_rd_elig, data_wr_elig, inst_rd_elig;
    logic sel_data, rd_hs, wr_hs, inst_rd_hs, data_rd_hs;
    logic inst_resp_ok, data_resp_ok, wr_resp_ok;
    logic fifo_full, fifo_empty, fifo_match;

    // Inst port is read-only; these inputs exist only for port symmetry.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, fifo_empty};

    // Reads and writes of the data port are never in flight together, so the
    // single data_ok stream stays in request order.
    assign data_rd_elig = data_sram_req && !data_sram_wr
                          && (rd_cnt_data_q < RD_MAX) && (wr_cnt_q == '0);
    assign data_wr_elig = data_sram_req && data_sram_wr
                          && (rd_cnt_data_q == '0) && (wr_cnt_q < WR_MAX) && !fifo_full;
    // A fetch from a word with a write still in flight could return stale code.
    assign inst_rd_elig = inst_sram_req && (rd_cnt_inst_q < RD_MAX) && !fifo_match;

    // Fixed priority: data read over inst read. Nothing here looks at ready.
    assign sel_data       = data_rd_elig;
    assign rd_issue_valid = data_rd_elig | inst_rd_elig;
    assign rd_issue_id    = sel_data ? ID_DATA : ID_INST;
    assign rd_issue_addr  = sel_data ? data_sram_addr : inst_sram_addr;
    assign rd_issue_size  = size_to_axsize(sel_data ? data_sram_size : inst_sram_size);

    assign wr_issue_valid = data_wr_elig;
    assign wr_issue_addr  = data_sram_addr;
    assign wr_issue_size  = size_to_axsize(data_sram_size);
    assign wr_issue_wstrb = data_sram_wstrb;
    assign wr_issue_wdata = data_sram_wdata;

    assign rd_hs      = rd_issue_valid & rd_issue_ready;
    assign wr_hs      = wr_issue_valid & wr_issue_ready;
    assign data_rd_hs = rd_hs & sel_data;
    assign inst_rd_hs = rd_hs & ~sel_data;

    assign inst_sram_addr_ok = inst_rd_hs;
    assign data_sram_addr_ok = data_rd_hs | wr_hs;

    // Responses for a requester with nothing outstanding are stray and dropped.
    assign inst_resp_ok = rd_resp_valid && (rd_resp_id == ID_INST) && (rd_cnt_inst_q != '0);
    assign data_resp_ok = rd_resp_valid && (rd_resp_id == ID_DATA) && (rd_cnt_data_q != '0);
    assign wr_resp_ok   = wr_resp_valid && (wr_cnt_q != '0);

    assign inst_sram_data_ok = inst_resp_ok;
    assign inst_sram_rdata   = inst_resp_ok ? rd_resp_data : 32'd0;
    assign data_sram_data_ok = data_resp_ok | wr_resp_ok;
    assign data_sram_rdata   = data_resp_ok ? rd_resp_data : 32'd0;

    always_comb begin
        rd_cnt_inst_d = rd_cnt_inst_q;
        rd_cnt_data_d = rd_cnt_data_q;
        wr_cnt_d      = wr_cnt_q;
        if (inst_rd_hs && !inst_resp_ok) rd_cnt_inst_d = rd_cnt_inst_q + RD_CW'(1);
        else if (!inst_rd_hs && inst_resp_ok) rd_cnt_inst_d = rd_cnt_inst_q - RD_CW'(1);
        if (data_rd_hs && !data_resp_ok) rd_cnt_data_d = rd_cnt_data_q + RD_CW'(1);
        else if (!data_rd_hs && data_resp_ok) rd_cnt_data_d = rd_cnt_data_q - RD_CW'(1);
        if (wr_hs && !wr_resp_ok) wr_cnt_d = wr_cnt_q + WR_CW'(1);
        else if (!wr_hs && wr_resp_ok) wr_cnt_d = wr_cnt_q - WR_CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_cnt_inst_q <= '0;
            rd_cnt_data_q <= '0;
            wr_cnt_q      <= '0;
        end else begin
            rd_cnt_inst_q <= rd_cnt_inst_d;
            rd_cnt_data_q <= rd_cnt_data_d;
            wr_cnt_q      <= wr_cnt_d;
        end
    end

    sram_wr_addr_fifo #(
        .DEPTH (MAX_WR_OUT),
        .WIDTH (WADDR_W)
    ) u_wr_addr_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (wr_hs),
        .push_addr   (data_sram_addr[31:2]),
        .pop         (wr_resp_ok),
        .lookup_addr (inst_sram_addr[31:2]),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .match       (fifo_match)
    );

    // The write engine only returns B after the read path has drained for data.
    a_no_rd_wr_resp_collision : assert property (@(posedge clk) disable iff (!resetn)
        !(rd_resp_valid && (rd_resp_id == ID_DATA) && wr_resp_valid));

endmodule
